alu_arbiter_2: RTL and testbench

ALU_ARBITER_2 -- requirements
Module: alu_arbiter_2

---
 rtl/alu_arbiter_2.sv | 122 ++++++++++++
 tb/tb_alu_arbiter_2.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_2.sv
// Two-requester round-robin front end for a shared registered ALU.
// Opcode 2'b10 is answered locally with an error response and never reaches the ALU.
module alu_arbiter_2 #(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [1:0]   i_req_valid,
    input  logic [N-1:0] i_req_op0,
    input  logic [N-1:0] i_req_op1,
    input  logic [M-1:0] i_req_a0,
    input  logic [M-1:0] i_req_a1,
    input  logic [M-1:0] i_req_b0,
    input  logic [M-1:0] i_req_b1,
    output logic [1:0]   o_req_ready,
    output logic [N-1:0] o_alu_op,
    output logic [M-1:0] o_alu_a,
    output logic [M-1:0] o_alu_b,
    input  logic [M-1:0] i_alu_result,
    input  logic [3:0]   i_alu_status,
    output logic         o_rsp_valid,
    output logic         o_rsp_id,
    output logic [M-1:0] o_rsp_result,
    output logic [3:0]   o_rsp_status,
    output logic         o_rsp_err,
    input  logic         i_rsp_ready,
    output logic         o_busy
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    localparam logic [N-1:0] OP_SUM = N'(2);

    state_t       state, state_nxt;
    logic         last_grant;
    logic [1:0]   grant;
    logic         hs;
    logic         grant_id;
    logic [N-1:0] sel_op;
    logic [M-1:0] sel_a;
    logic [M-1:0] sel_b;

    // Round-robin pick: on contention the requester not served last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
        if (valid == 2'b11)
            return last ? 2'b01 : 2'b10;
        return valid;
    endfunction

    always_comb begin
        grant = 2'b00;
        if (state == IDLE && !i_reset)
            grant = rr_pick(i_req_valid, last_grant);
    end

    assign o_req_ready = grant;
    assign hs          = |grant;
    assign grant_id    = grant[1];
    assign sel_op      = grant_id ? i_req_op1 : i_req_op0;
    assign sel_a       = grant_id ? i_req_a1  : i_req_a0;
    assign sel_b       = grant_id ? i_req_b1  : i_req_b0;
    assign o_rsp_valid = (state == RESP);
    assign o_busy      = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (hs) state_nxt = (sel_op == OP_SUM) ? RESP : EXEC;
            EXEC: state_nxt = CAPT;
            CAPT: state_nxt = RESP;
            RESP: if (i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU operands are only loaded on an accepted ALU op, so they stay put through RESP.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_alu_op     <= '0;
            o_alu_a      <= '0;
            o_alu_b      <= '0;
            o_rsp_id     <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_status <= '0;
            o_rsp_err    <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        o_rsp_id <= grant_id;
                        if (sel_op == OP_SUM) begin
                            o_rsp_result <= '0;
                            o_rsp_status <= '0;
                            o_rsp_err    <= 1'b1;
                        end else begin
                            o_alu_op <= sel_op;
                            o_alu_a  <= sel_a;
                            o_alu_b  <= sel_b;
                        end
                    end
                end
                CAPT: begin
                    o_rsp_result <= i_alu_result;
                    o_rsp_status <= i_alu_status;
                    o_rsp_err    <= 1'b0;
                end
                RESP: if (i_rsp_ready) last_grant <= o_rsp_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter_2.sv
// Directed bench for alu_arbiter_2 with a small registered ALU model attached.
module tb_alu_arbiter_2;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [1:0] i_req_valid;
    logic [1:0] i_req_op0, i_req_op1;
    logic [3:0] i_req_a0, i_req_a1, i_req_b0, i_req_b1;
    logic [1:0] o_req_ready;
    logic [1:0] o_alu_op;
    logic [3:0] o_alu_a, o_alu_b;
    logic [3:0] i_alu_result, i_alu_status;
    logic       o_rsp_valid, o_rsp_id, o_rsp_err, o_busy;
    logic [3:0] o_rsp_result, o_rsp_status;
    logic       i_rsp_ready;

    int total = 0;
    int bad = 0;

    always #5 i_clk = ~i_clk;

    alu_arbiter_2 #(.N(2), .M(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid),
        .i_req_op0(i_req_op0), .i_req_op1(i_req_op1),
        .i_req_a0(i_req_a0), .i_req_a1(i_req_a1),
        .i_req_b0(i_req_b0), .i_req_b1(i_req_b1),
        .o_req_ready(o_req_ready), .o_alu_op(o_alu_op),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .i_alu_result(i_alu_result), .i_alu_status(i_alu_status),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
        .o_rsp_result(o_rsp_result), .o_rsp_status(o_rsp_status),
        .o_rsp_err(o_rsp_err), .i_rsp_ready(i_rsp_ready), .o_busy(o_busy)
    );

    // ALU model: 00 = A>>1, 01 = A&B, 11 = rotate-left A; status = {zero, msb, 2'b10}
    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        case (op)
            2'b00:   r = a >> 1;
            2'b01:   r = a & b;
            2'b11:   r = {a[2:0], a[3]};
            default: r = 4'd0;
        endcase
        return {r, (r == 4'd0), r[3], 2'b10};
    endfunction

    always_ff @(posedge i_clk) begin
        {i_alu_result, i_alu_status} <= alu_f(o_alu_op, o_alu_a, o_alu_b);
    end

    typedef struct {
        logic [1:0] valid;
        logic [1:0] op0; logic [3:0] a0; logic [3:0] b0;
        logic [1:0] op1; logic [3:0] a1; logic [3:0] b1;
        logic [1:0] grant;
        logic [3:0] res; logic [3:0] st; logic err;
    } vec_t;

    vec_t tbl[8];

    logic [1:0] exp_op;
    logic [3:0] exp_a, exp_b;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 1;
        while (!o_rsp_valid && cycles < 10) begin
            tick();
            #1;
            cycles++;
        end
    endtask

    initial begin
        int         lat;
        int         n;
        logic       dbl;
        logic [3:0] gseq;

        tbl[0] = '{2'b01, 2'b00, 4'd7,    4'd2,    2'b00, 4'd0,    4'd0,    2'b01, 4'b0011, 4'b0010, 1'b0};
        tbl[1] = '{2'b10, 2'b00, 4'd0,    4'd0,    2'b11, 4'b1101, 4'd0,    2'b10, 4'b1011, 4'b0110, 1'b0};
        tbl[2] = '{2'b11, 2'b01, 4'b1100, 4'b1010, 2'b00, 4'd8,    4'd1,    2'b01, 4'b1000, 4'b0110, 1'b0};
        tbl[3] = '{2'b11, 2'b00, 4'd9,    4'd9,    2'b01, 4'b0011, 4'b1100, 2'b10, 4'b0000, 4'b1010, 1'b0};
        tbl[4] = '{2'b01, 2'b10, 4'd5,    4'd6,    2'b00, 4'd0,    4'd0,    2'b01, 4'b0000, 4'b0000, 1'b1};
        tbl[5] = '{2'b10, 2'b00, 4'd0,    4'd0,    2'b10, 4'd3,    4'd4,    2'b10, 4'b0000, 4'b0000, 1'b1};
        tbl[6] = '{2'b11, 2'b11, 4'b1000, 4'd0,    2'b00, 4'd1,    4'd0,    2'b01, 4'b0001, 4'b0010, 1'b0};
        tbl[7] = '{2'b11, 2'b01, 4'd2,    4'd2,    2'b00, 4'b1111, 4'd3,    2'b10, 4'b0111, 4'b0010, 1'b0};

        i_reset = 1'b1; i_req_valid = 2'b11; i_rsp_ready = 1'b0;
        i_req_op0 = '0; i_req_op1 = '0; i_req_a0 = '0; i_req_a1 = '0; i_req_b0 = '0; i_req_b1 = '0;
        exp_op = '0; exp_a = '0; exp_b = '0;
        tick(); tick(); #1;
        chk("rst_ready", {6'd0, o_req_ready}, 8'd0);
        chk("rst_busy", {7'd0, o_busy}, 8'd0);
        chk("rst_rsp_valid", {7'd0, o_rsp_valid}, 8'd0);
        chk("rst_alu", {o_alu_op, o_alu_a[1:0], o_alu_b}, 8'd0);
        chk("rst_rsp", {o_rsp_result, o_rsp_status}, 8'd0);
        chk("rst_id_err", {6'd0, o_rsp_id, o_rsp_err}, 8'd0);
        i_reset = 1'b0; i_req_valid = 2'b00;
        tick();

        for (int i = 0; i < 8; i++) begin
            i_req_valid = tbl[i].valid;
            i_req_op0 = tbl[i].op0; i_req_a0 = tbl[i].a0; i_req_b0 = tbl[i].b0;
            i_req_op1 = tbl[i].op1; i_req_a1 = tbl[i].a1; i_req_b1 = tbl[i].b1;
            #1;
            chk($sformatf("v%0d_grant", i), {6'd0, o_req_ready}, {6'd0, tbl[i].grant});
            if (tbl[i].grant[1] ? (tbl[i].op1 != 2'b10) : (tbl[i].op0 != 2'b10)) begin
                exp_op = tbl[i].grant[1] ? tbl[i].op1 : tbl[i].op0;
                exp_a  = tbl[i].grant[1] ? tbl[i].a1  : tbl[i].a0;
                exp_b  = tbl[i].grant[1] ? tbl[i].b1  : tbl[i].b0;
            end
            tick();
            i_req_valid = 2'b00;
            #1;
            wait_rsp(lat);
            chk($sformatf("v%0d_latency", i), 8'(lat), tbl[i].err ? 8'd1 : 8'd3);
            chk($sformatf("v%0d_id", i), {7'd0, o_rsp_id}, {7'd0, tbl[i].grant[1]});
            chk($sformatf("v%0d_result", i), {o_rsp_result, o_rsp_status}, {tbl[i].res, tbl[i].st});
            chk($sformatf("v%0d_err", i), {7'd0, o_rsp_err}, {7'd0, tbl[i].err});
            chk($sformatf("v%0d_alu", i), {o_alu_op, o_alu_a, o_alu_b[1:0]}, {exp_op, exp_a, exp_b[1:0]});
            i_rsp_ready = 1'b1;
            tick();
            i_rsp_ready = 1'b0;
            #1;
            chk($sformatf("v%0d_idle", i), {6'd0, o_busy, o_rsp_valid}, 8'd0);
        end

        // Back-pressure: response must hold while consumer stalls; requests are not taken.
        i_req_valid = 2'b01; i_req_op0 = 2'b01; i_req_a0 = 4'b1111; i_req_b0 = 4'b0101;
        #1;
        chk("bp_grant", {6'd0, o_req_ready}, 8'd1);
        tick();
        i_req_valid = 2'b00;
        #1;
        wait_rsp(lat);
        chk("bp_latency", 8'(lat), 8'd3);
        for (int c = 0; c < 5; c++) begin
            i_req_valid = (c % 2 == 0) ? 2'b11 : 2'b00;
            #1;
            chk("bp_hold", {o_rsp_result, o_rsp_status}, {4'b0101, 4'b0010});
            chk("bp_ctl", {3'd0, o_rsp_valid, o_rsp_id, o_rsp_err, o_req_ready}, 8'b0001_0000);
            tick();
        end
        i_req_valid = 2'b00; i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        #1;
        chk("bp_release", {6'd0, o_busy, o_rsp_valid}, 8'd0);

        // Reset in CAPT, then continuous contention from a fresh pointer.
        i_req_valid = 2'b10; i_req_op1 = 2'b00; i_req_a1 = 4'd6;
        #1;
        chk("rc_grant", {6'd0, o_req_ready}, 8'b10);
        tick();
        i_req_valid = 2'b00;
        tick();
        #1;
        chk("rc_in_capt", {6'd0, o_busy, o_rsp_valid}, 8'b10);
        i_reset = 1'b1; i_req_valid = 2'b11;
        tick();
        #1;
        chk("rc_ctl", {4'd0, o_busy, o_rsp_valid, o_req_ready}, 8'd0);
        chk("rc_alu", {o_alu_op, o_alu_a[1:0], o_alu_b}, 8'd0);
        chk("rc_rsp", {o_rsp_result, o_rsp_status}, 8'd0);
        chk("rc_id_err", {6'd0, o_rsp_id, o_rsp_err}, 8'd0);
        i_reset = 1'b0; i_rsp_ready = 1'b1;
        i_req_op0 = 2'b00; i_req_op1 = 2'b00;
        #1;
        chk("rc_first_grant", {6'd0, o_req_ready}, 8'b01);

        n = 0; dbl = 1'b0; gseq = 4'd0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            if (o_req_ready == 2'b11) dbl = 1'b1;
            if (o_req_ready != 2'b00) begin
                gseq[n] = o_req_ready[1];
                n++;
            end
            tick();
            #1;
        end
        chk("rr_count", 8'(n), 8'd4);
        chk("rr_order", {4'd0, gseq}, 8'b0000_1010);
        chk("rr_onehot", {7'd0, dbl}, 8'd0);
        i_req_valid = 2'b00; i_rsp_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
